tdm_demux: RTL and testbench

Time-division demultiplexer: the receive end of the slot-select multiplexer path. A serial line carries one bit per slot, and a frame marker identifies slot 0. The block steps a slot counter, steers each bit into its slot's position, and presents a complete parallel frame of NSLOTS bits with a one-cycle valid pulse. It sits between the serial link and downstream parallel logic.

---
 rtl/tdm_demux_pkg.sv | 11 +
 rtl/tdm_demux_slot_counter.sv | 46 ++++
 rtl/tdm_demux.sv | 124 ++++++++++++
 tb/tb_tdm_demux.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared constants for the TDM mux/demux pair: FSM encodings and default
// frame geometry, so both ends agree on slot numbering.
package tdm_demux_pkg;

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int NSLOTS_DEF = 7;
  localparam int ADDR_W_DEF = 3;

endpackage

// File: rtl/tdm_demux_slot_counter.sv
// Modulo-NSLOTS slot counter with clear, load-to-1 and increment controls.
// Priority: clr, then load1, then inc.
module slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int NSLOTS = NSLOTS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NSLOTS - 1);

  logic [ADDR_W-1:0] count_reg;
  logic [ADDR_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (load1) begin
      count_next = ADDR_W'(1);
    end else if (inc) begin
      // wrap at NSLOTS, not at 2**ADDR_W
      count_next = (count_reg == LAST_SLOT) ? '0 : count_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == LAST_SLOT);

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: steers serial slot bits into a shadow frame
// and publishes each complete frame with a one-cycle frame_valid pulse.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int NSLOTS = NSLOTS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync_in,
  input  logic              data_in,
  output logic [NSLOTS-1:0] out,
  output logic              frame_valid,
  output logic [ADDR_W-1:0] slot_addr,
  output logic              locked,
  output logic              sync_err
);

  logic [0:0]        state_reg, state_next;
  logic [NSLOTS-1:0] shadow_reg, shadow_next;
  logic [NSLOTS-1:0] out_reg, out_next;
  logic              frame_valid_reg, frame_valid_next;
  logic              sync_err_reg, sync_err_next;

  logic              cnt_clr, cnt_load1, cnt_inc;
  logic              cnt_last;
  logic [ADDR_W-1:0] cnt;

  logic [NSLOTS-1:0] slot_sel;
  logic [NSLOTS-1:0] merged;
  logic [NSLOTS-1:0] first_bit;

  slot_counter #(
    .NSLOTS(NSLOTS),
    .ADDR_W(ADDR_W)
  ) u_slot_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .load1(cnt_load1),
    .inc  (cnt_inc),
    .count(cnt),
    .last (cnt_last)
  );

  // one-hot decode of the current slot for the shadow write
  for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_sel
    assign slot_sel[gi] = (cnt == ADDR_W'(gi));
  end

  assign merged    = (shadow_reg & ~slot_sel) | ({NSLOTS{data_in}} & slot_sel);
  assign first_bit = {{(NSLOTS-1){1'b0}}, data_in};

  always_comb begin
    state_next       = state_reg;
    shadow_next      = shadow_reg;
    out_next         = out_reg;
    frame_valid_next = 1'b0;
    sync_err_next    = 1'b0;
    cnt_clr          = 1'b0;
    cnt_load1        = 1'b0;
    cnt_inc          = 1'b0;
    if (en) begin
      case (state_reg)
        ST_HUNT: begin
          if (sync_in) begin
            state_next  = ST_LOCKED;
            shadow_next = first_bit;
            cnt_load1   = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (sync_in) begin
            // marker always restarts a frame; off slot 0 it is also an error
            shadow_next   = first_bit;
            cnt_load1     = 1'b1;
            sync_err_next = (cnt != '0);
          end else if (cnt == '0) begin
            sync_err_next = 1'b1;
            state_next    = ST_HUNT;
            cnt_clr       = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
              out_next         = merged;
              frame_valid_next = 1'b1;
            end else begin
              shadow_next = merged;
            end
          end
        end
        default: begin
          state_next = ST_HUNT;
          cnt_clr    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_HUNT;
      shadow_reg      <= '0;
      out_reg         <= '0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shadow_reg      <= shadow_next;
      out_reg         <= out_next;
      frame_valid_reg <= frame_valid_next;
      sync_err_reg    <= sync_err_next;
    end
  end

  assign out         = out_reg;
  assign frame_valid = frame_valid_reg;
  assign slot_addr   = cnt;
  assign locked      = (state_reg == ST_LOCKED);
  assign sync_err    = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: expected frames are queued as the last slot
// is driven and compared when frame_valid appears.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       sync_in;
  logic       data_in;
  logic [6:0] out;
  logic       frame_valid;
  logic [2:0] slot_addr;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fv_t_last = 0;
  int fv_t_prev = 0;
  logic [6:0] exp_q[$];

  tdm_demux #(.NSLOTS(7), .ADDR_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sync_in    (sync_in),
    .data_in    (data_in),
    .out        (out),
    .frame_valid(frame_valid),
    .slot_addr  (slot_addr),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard side: every frame_valid pulse consumes one expected frame
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_t_prev = fv_t_last;
      fv_t_last = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_valid", {25'd0, out}, 32'hFFFF_FFFF);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        chk("frame_out", {25'd0, out}, {25'd0, e});
        $display("frame out=%02h expected=%02h at cycle %0d", out, e, cyc);
      end
    end
  end

  task automatic step(input logic e, input logic s, input logic d);
    en = e; sync_in = s; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_slots(input logic [6:0] f, input int first, input int last_i);
    for (int i = first; i <= last_i; i++) begin
      if (i == 6) exp_q.push_back(f);
      step(1'b1, i == 0, f[i]);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; sync_in = 1'b0; data_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {25'd0, out}, 32'd0);
    chk("reset_fv", {31'd0, frame_valid}, 32'd0);
    chk("reset_slot", {29'd0, slot_addr}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_err", {31'd0, sync_err}, 32'd0);
    reset = 1'b0;

    // 1: basic frame 0x4D
    send_slots(7'h4D, 0, 0);
    chk("t1_locked", {31'd0, locked}, 32'd1);
    chk("t1_slot1", {29'd0, slot_addr}, 32'd1);
    send_slots(7'h4D, 1, 6);
    chk("t1_fv", {31'd0, frame_valid}, 32'd1);
    chk("t1_out", {25'd0, out}, 32'h4D);
    chk("t1_err", {31'd0, sync_err}, 32'd0);
    chk("t1_wrap", {29'd0, slot_addr}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("t1_fv_pulse", {31'd0, frame_valid}, 32'd0);

    // 2: en gaps between slots 2 and 3
    send_slots(7'h4D, 0, 2);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, g[0], ~g[0]);
      chk("t2_gap_slot", {29'd0, slot_addr}, 32'd3);
      chk("t2_gap_err", {31'd0, sync_err}, 32'd0);
      chk("t2_gap_fv", {31'd0, frame_valid}, 32'd0);
    end
    send_slots(7'h4D, 3, 6);
    chk("t2_out", {25'd0, out}, 32'h4D);

    // 3: early marker after 4 slots
    send_slots(7'h7F, 0, 3);
    step(1'b1, 1'b1, 1'b1);
    chk("t3_err", {31'd0, sync_err}, 32'd1);
    chk("t3_fv", {31'd0, frame_valid}, 32'd0);
    chk("t3_slot", {29'd0, slot_addr}, 32'd1);
    chk("t3_out_kept", {25'd0, out}, 32'h4D);
    chk("t3_locked", {31'd0, locked}, 32'd1);
    send_slots(7'h01, 1, 6);
    chk("t3_out", {25'd0, out}, 32'h01);
    chk("t3_err_clear", {31'd0, sync_err}, 32'd0);

    // 4: missed marker at frame boundary, then ignored bits and relock
    step(1'b1, 1'b0, 1'b1);
    chk("t4_err", {31'd0, sync_err}, 32'd1);
    chk("t4_locked", {31'd0, locked}, 32'd0);
    chk("t4_slot", {29'd0, slot_addr}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("t4_hunt_locked", {31'd0, locked}, 32'd0);
      chk("t4_hunt_slot", {29'd0, slot_addr}, 32'd0);
      chk("t4_hunt_err", {31'd0, sync_err}, 32'd0);
    end
    chk("t4_out_kept", {25'd0, out}, 32'h01);
    send_slots(7'h2A, 0, 6);
    chk("t4_relock_out", {25'd0, out}, 32'h2A);

    // 5: reset mid-frame
    send_slots(7'h7F, 0, 2);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    reset = 1'b0;
    chk("t5_out", {25'd0, out}, 32'd0);
    chk("t5_locked", {31'd0, locked}, 32'd0);
    chk("t5_slot", {29'd0, slot_addr}, 32'd0);
    chk("t5_fv", {31'd0, frame_valid}, 32'd0);
    send_slots(7'h55, 0, 6);
    chk("t5_out_new", {25'd0, out}, 32'h55);

    // 6: back-to-back frames
    send_slots(7'h4D, 0, 6);
    chk("t6_out_a", {25'd0, out}, 32'h4D);
    send_slots(7'h32, 0, 6);
    chk("t6_out_b", {25'd0, out}, 32'h32);
    step(1'b0, 1'b0, 1'b0);
    chk("t6_spacing", fv_t_last - fv_t_prev, 32'd7);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
